dwt_lift_step: RTL and testbench
================================

// Module: dwt_lift_step
// PURPOSE
//   One predict/update lifting step of the line-wise DWT: odd'[n] = odd[n] + Coef*(even[n]+even[n+1]).
//   Consumes (even,odd) sample pairs of a line; emits (even[n], odd'[n]) pairs to the next lifting step.
//   Right-edge symmetric extension: even[N] := even[N-1]. Fixed-point sums use the codebase's Qx.Point format.
// PARAMETERS
//   Width = 16      sample / coefficient word width, signed two's complement
//   Point = 10      fractional bits of samples and Coef
//   Coef  = -512    signed Width-bit lifting coefficient, Q(Width-Point).Point (-512 = -0.5)
// PORTS
//   clk_i       in   1      clock, all state on rising edge
//   rst_n_i     in   1      asynchronous reset, active low
//   s_valid_i   in   1      input pair valid
//   s_ready_o   out  1      input pair accepted when s_valid_i & s_ready_o
//   s_even_i    in   Width  even sample
//   s_odd_i     in   Width  odd sample
//   s_last_i    in   1      pair is last of line
//   m_valid_o   out  1      output pair valid
//   m_ready_i   in   1      downstream accepts when m_valid_o & m_ready_i
//   m_even_o    out  Width  even sample, passed through unchanged
//   m_odd_o     out  Width  lifted odd sample
//   m_last_o    out  1      output pair is last of line
// BEHAVIOUR
//   Reset: state EMPTY, m_valid_o=0, m_even_o=0, m_odd_o=0, m_last_o=0, hold regs 0.
//   Output slot: one register; slot_free = !m_valid_o | m_ready_i; m_* stable while m_valid_o & !m_ready_i.
//   States: EMPTY (no pending pair), HOLD (pending pair P held), FLUSH (pending last pair P).
//   s_ready_o = EMPTY | (HOLD & slot_free); 0 in FLUSH.
//   EMPTY, accept X: P:=X; -> FLUSH if X.last else HOLD. No output.
//   HOLD, accept X: load slot with (P.even, lift(P, X.even), last=0); P:=X; -> FLUSH if X.last else HOLD.
//   FLUSH, slot_free: load slot with (P.even, lift(P, P.even), last=1); -> EMPTY.
//   Slot drained (m_ready_i) with no new load in same cycle -> m_valid_o:=0.
//   lift(P,e): sum = P.even + e (Width+1 bits); prod = sum*Coef (2*Width+1 bits);
//     shifted = prod >>> Point (arithmetic, floor rounding); res = P.odd + shifted; narrowed to Width.
//   Latency: pair n appears the cycle after pair n+1 (or the FLUSH cycle) — min 1 cycle, pair-level delay 1.
//   Throughput: 1 pair/cycle under continuous valid/ready; one bubble per line (FLUSH).
//   Single-pair line (last in EMPTY): FLUSH directly; even mirrored onto itself.
//   Reset mid-line: all state cleared; next accepted pair starts a new line.
//   No data lost or duplicated under any m_ready_i pattern.
// CONFIGURATION
//   DWT_LIFT_SATURATE_EN defined: res clamped to [-2^(Width-1), 2^(Width-1)-1].
//   Not defined: res truncated to low Width bits (two's complement wrap). Default build: undefined.
// STRUCTURE
//   dwt_pkg: sample_t (logic signed [Width-1:0]), lift_state_e {EMPTY,HOLD,FLUSH}, sat/narrow function.
//   Sub-module dwt_lift_mac (combinational): sum, multiply, shift, add, narrow/saturate.
//   Top: FSM, hold register, output slot register.
// TESTING  (Width=16, Point=10, Coef=-512 unless stated)
//   1 line even 100,200,300 odd 0,0,0 last on 3rd -> out odd -150,-250,-300; even 100,200,300; m_last_o on 3rd only.
//   2 single pair (40,7,last) -> one output (40,-33,last=1); s_ready_o low exactly 1 cycle (FLUSH).
//   3 m_ready_i low 5 cycles mid-stream -> s_ready_o drops after slot fills; m_* held stable; sequence intact.
//   4 Coef=1024, pairs (30000,30000),(30000,x,last) -> first odd 32767 with DWT_LIFT_SATURATE_EN, 24464 without.
//   5 even 1,0 odd 0 -> first odd -1 (floor of -0.5), not 0.
//   6 rst_n_i low while HOLD with m_valid_o=1 -> m_valid_o=0 immediately; next pair treated as line start.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared types and helpers for the line-wise DWT lifting steps.
// Sample format is signed two's complement with POINT fractional bits.
package dwt_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned POINT = 10;

    typedef logic signed [WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        FLUSH
    } lift_state_e;

    // Clamp v to the signed w-bit range when sat is set; the caller keeps the low w bits.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                                  input int unsigned       w,
                                                  input bit                sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (sat && (v > hi)) return hi;
        if (sat && (v < lo)) return lo;
        return v;
    endfunction

endpackage

// File: rtl/dwt_lift_mac.sv
// Combinational lifting kernel: odd + floor(Coef*(even_a+even_b) / 2^Point).
// DWT_LIFT_SATURATE_EN selects clamping of the result instead of two's complement wrap.
module dwt_lift_mac
    import dwt_pkg::*;
#(
    parameter int unsigned              Width = WIDTH,
    parameter int unsigned              Point = POINT,
    parameter logic signed [Width-1:0]  Coef  = -512
) (
    input  logic signed [Width-1:0] i_odd,
    input  logic signed [Width-1:0] i_even_a,
    input  logic signed [Width-1:0] i_even_b,
    output logic signed [Width-1:0] o_res
);

`ifdef DWT_LIFT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic signed [Width:0]     w_sum;
    logic signed [2*Width:0]   w_sum_x;
    logic signed [2*Width:0]   w_coef_x;
    logic signed [2*Width:0]   w_prod;
    logic signed [2*Width:0]   w_shift;
    logic signed [2*Width+1:0] w_res;

    assign w_sum    = {i_even_a[Width-1], i_even_a} + {i_even_b[Width-1], i_even_b};
    assign w_sum_x  = {{Width{w_sum[Width]}}, w_sum};
    assign w_coef_x = {{(Width+1){Coef[Width-1]}}, Coef};
    assign w_prod   = w_sum_x * w_coef_x;
    // Arithmetic shift of a signed product rounds toward minus infinity.
    assign w_shift  = w_prod >>> Point;
    assign w_res    = {{(Width+2){i_odd[Width-1]}}, i_odd} + {w_shift[2*Width], w_shift};
    assign o_res    = Width'(narrow(64'(w_res), Width, SAT));

endmodule

// File: rtl/dwt_lift_step.sv
// One predict/update lifting step over (even, odd) pairs with right-edge mirroring.
// Build option DWT_LIFT_SATURATE_EN (in dwt_lift_mac) clamps instead of wrapping.
module dwt_lift_step
    import dwt_pkg::*;
#(
    parameter int unsigned              Width = WIDTH,
    parameter int unsigned              Point = POINT,
    parameter logic signed [Width-1:0]  Coef  = -512
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic signed [Width-1:0] s_even_i,
    input  logic signed [Width-1:0] s_odd_i,
    input  logic                    s_last_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic signed [Width-1:0] m_even_o,
    output logic signed [Width-1:0] m_odd_o,
    output logic                    m_last_o
);

    lift_state_e             r_state;
    logic signed [Width-1:0] r_p_even;
    logic signed [Width-1:0] r_p_odd;
    logic                    r_m_valid;
    logic signed [Width-1:0] r_m_even;
    logic signed [Width-1:0] r_m_odd;
    logic                    r_m_last;

    logic                    w_slot_free;
    logic                    w_accept;
    logic signed [Width-1:0] w_even_b;
    logic signed [Width-1:0] w_lift;

    assign w_slot_free = !r_m_valid || m_ready_i;
    assign s_ready_o   = (r_state == EMPTY) || ((r_state == HOLD) && w_slot_free);
    assign w_accept    = s_valid_i && s_ready_o;
    // At the line end the held even sample is mirrored onto itself.
    assign w_even_b    = (r_state == FLUSH) ? r_p_even : s_even_i;

    dwt_lift_mac #(
        .Width (Width),
        .Point (Point),
        .Coef  (Coef)
    ) u_mac (
        .i_odd    (r_p_odd),
        .i_even_a (r_p_even),
        .i_even_b (w_even_b),
        .o_res    (w_lift)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= EMPTY;
            r_p_even  <= '0;
            r_p_odd   <= '0;
            r_m_valid <= 1'b0;
            r_m_even  <= '0;
            r_m_odd   <= '0;
            r_m_last  <= 1'b0;
        end else begin
            if (r_m_valid && m_ready_i) r_m_valid <= 1'b0;
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_p_even <= s_even_i;
                        r_p_odd  <= s_odd_i;
                        r_state  <= s_last_i ? FLUSH : HOLD;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_m_valid <= 1'b1;
                        r_m_even  <= r_p_even;
                        r_m_odd   <= w_lift;
                        r_m_last  <= 1'b0;
                        r_p_even  <= s_even_i;
                        r_p_odd   <= s_odd_i;
                        r_state   <= s_last_i ? FLUSH : HOLD;
                    end
                end
                FLUSH: begin
                    if (w_slot_free) begin
                        r_m_valid <= 1'b1;
                        r_m_even  <= r_p_even;
                        r_m_odd   <= w_lift;
                        r_m_last  <= 1'b1;
                        r_state   <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign m_valid_o = r_m_valid;
    assign m_even_o  = r_m_even;
    assign m_odd_o   = r_m_odd;
    assign m_last_o  = r_m_last;

endmodule

// File: tb/tb_dwt_lift_step.sv
// Randomized self-checking bench for dwt_lift_step against a line-level lifting model.
// Honours DWT_LIFT_SATURATE_EN to pick clamp or wrap in the reference.
module tb_dwt_lift_step;
    import dwt_pkg::*;

    typedef struct {
        longint e;
        longint o;
        bit     last;
    } pair_t;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    s_valid = 1'b0;
    logic    s_ready;
    sample_t s_even = '0;
    sample_t s_odd = '0;
    logic    s_last = 1'b0;
    logic    m_valid;
    logic    m_ready = 1'b1;
    sample_t m_even;
    sample_t m_odd;
    logic    m_last;

    logic    s_valid_b = 1'b0;
    logic    s_ready_b;
    sample_t s_even_b = '0;
    sample_t s_odd_b = '0;
    logic    s_last_b = 1'b0;
    logic    m_valid_b;
    logic    m_ready_b = 1'b1;
    sample_t m_even_b;
    sample_t m_odd_b;
    logic    m_last_b;

    int      n_checks = 0;
    int      n_fail = 0;
    bit      force_low = 1'b0;
    bit      rand_ready = 1'b0;
    pair_t   in_q[$];
    pair_t   obs_q[$];
    pair_t   obs_b[$];

    always #5 clk = ~clk;

    dwt_lift_step u_dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_even_i  (s_even),
        .s_odd_i   (s_odd),
        .s_last_i  (s_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_even_o  (m_even),
        .m_odd_o   (m_odd),
        .m_last_o  (m_last)
    );

    dwt_lift_step #(
        .Width (16),
        .Point (10),
        .Coef  (16'sd1024)
    ) u_dut_b (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .s_valid_i (s_valid_b),
        .s_ready_o (s_ready_b),
        .s_even_i  (s_even_b),
        .s_odd_i   (s_odd_b),
        .s_last_i  (s_last_b),
        .m_valid_o (m_valid_b),
        .m_ready_i (m_ready_b),
        .m_even_o  (m_even_b),
        .m_odd_o   (m_odd_b),
        .m_last_o  (m_last_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // odd + floor(coef*(e0+e1)/1024), then clamp or wrap to 16 bits
    function automatic longint lift_ref(longint odd, longint e0, longint e1, longint coef);
        longint p, q, r;
        p = (e0 + e1) * coef;
        q = p / 1024;
        if ((p % 1024 != 0) && (p < 0)) q = q - 1;
        r = odd + q;
`ifdef DWT_LIFT_SATURATE_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`else
        r = ((r % 65536) + 65536) % 65536;
        if (r >= 32768) r = r - 65536;
`endif
        return r;
    endfunction

    initial forever begin
        @(negedge clk);
        m_ready = force_low ? 1'b0 : (rand_ready ? ($urandom_range(3) != 0) : 1'b1);
    end

    always @(posedge clk) begin
        if (rst_n && m_valid && m_ready) obs_q.push_back('{longint'(m_even), longint'(m_odd), m_last});
        if (rst_n && m_valid_b && m_ready_b) obs_b.push_back('{longint'(m_even_b), longint'(m_odd_b), m_last_b});
    end

    bit      stall_prev = 1'b0;
    sample_t prev_e, prev_o;
    logic    prev_l;
    always @(posedge clk) begin
        if (rst_n && stall_prev) begin
            check("hold_valid", m_valid, 1);
            check("hold_even", m_even, prev_e);
            check("hold_odd", m_odd, prev_o);
            check("hold_last", m_last, prev_l);
        end
        stall_prev <= rst_n && m_valid && !m_ready;
        prev_e <= m_even;
        prev_o <= m_odd;
        prev_l <= m_last;
    end

    task automatic send(input longint e, input longint o, input bit last);
        int n;
        @(negedge clk);
        s_valid = 1'b1;
        s_even = sample_t'(e);
        s_odd = sample_t'(o);
        s_last = last;
        #1;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            check("send_ready_timeout", s_ready, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        in_q.push_back('{longint'(s_even), longint'(s_odd), last});
        #1 s_valid = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        int n;
        longint nxt;
        n = 0;
        while (obs_q.size() < in_q.size() && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_count"}, obs_q.size(), in_q.size());
        for (int unsigned i = 0; i < in_q.size() && i < obs_q.size(); i++) begin
            nxt = (in_q[i].last || i + 1 >= in_q.size()) ? in_q[i].e : in_q[i+1].e;
            check({tag, "_even"}, obs_q[i].e, in_q[i].e);
            check({tag, "_odd"}, obs_q[i].o, lift_ref(in_q[i].o, in_q[i].e, nxt, -512));
            check({tag, "_last"}, obs_q[i].last, in_q[i].last);
        end
    endtask

    initial begin
        int lows;
        bit saw_drop;
        longint exp_b0;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        bit saw_drop;
        longint exp_b0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_even", m_even, 0);
        check("rst_m_odd", m_odd, 0);
        check("rst_m_last", m_last, 0);
        check("rst_s_ready", s_ready, 1);
        rst_n = 1'b1;

        // directed line with known results
        send(100, 0, 0);
        send(200, 0, 0);
        send(300, 0, 1);
        drain_check("t1");
        if (obs_q.size() == 3) begin
            check("t1_odd0", obs_q[0].o, -150);
            check("t1_odd1", obs_q[1].o, -250);
            check("t1_odd2", obs_q[2].o, -300);
            check("t1_last1", obs_q[1].last, 0);
            check("t1_last2", obs_q[2].last, 1);
        end
        in_q.delete();
        obs_q.delete();

        // single-pair line goes straight to FLUSH
        send(40, 7, 1);
        lows = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (!s_ready) lows++;
        end
        check("t2_ready_low_cycles", lows, 1);
        drain_check("t2");
        if (obs_q.size() == 1) begin
            check("t2_odd", obs_q[0].o, -33);
            check("t2_last", obs_q[0].last, 1);
        end
        in_q.delete();
        obs_q.delete();

        // downstream stall mid-stream
        saw_drop = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send(i * 37 - 100, i * 11, i == 7);
            begin
                repeat (3) @(posedge clk);
                #3 force_low = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    #2;
                    if (!s_ready) saw_drop = 1'b1;
                end
                force_low = 1'b0;
            end
        join
        check("t3_s_ready_dropped", saw_drop, 1);
        drain_check("t3");
        in_q.delete();
        obs_q.delete();

        // reset while HOLD with a pending output, then floor rounding on a fresh line
        force_low = 1'b1;
        send(10, 1, 0);
        send(20, 2, 0);
        @(negedge clk);
        #1;
        check("t6_pre_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_ready", s_ready, 1);
        in_q.delete();
        obs_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        force_low = 1'b0;
        send(1, 0, 0);
        send(0, 0, 1);
        drain_check("t5");
        if (obs_q.size() > 0) check("t5_floor", obs_q[0].o, -1);
        in_q.delete();
        obs_q.delete();

        // randomized lines under random backpressure
        rand_ready = 1'b1;
        for (int l = 0; l < 25; l++) begin
            int len;
            len = $urandom_range(6, 1);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(4) == 0) @(negedge clk);
                send(longint'($signed(16'($urandom))), longint'($signed(16'($urandom))), k == len - 1);
            end
        end
        drain_check("rnd");
        in_q.delete();
        obs_q.delete();
        rand_ready = 1'b0;

        // Coef = +1.0 overflow case on the second instance
        @(negedge clk);
        s_valid_b = 1'b1;
        s_even_b = 16'sd30000;
        s_odd_b = 16'sd30000;
        s_last_b = 1'b0;
        #1 check("b_ready0", s_ready_b, 1);
        @(posedge clk);
        #1 s_valid_b = 1'b0;
        @(negedge clk);
        s_valid_b = 1'b1;
        s_even_b = 16'sd30000;
        s_odd_b = 16'sd0;
        s_last_b = 1'b1;
        #1 check("b_ready1", s_ready_b, 1);
        @(posedge clk);
        #1 s_valid_b = 1'b0;
        repeat (5) @(negedge clk);
`ifdef DWT_LIFT_SATURATE_EN
        exp_b0 = 32767;
`else
        exp_b0 = 24464;
`endif
        check("b_count", obs_b.size(), 2);
        if (obs_b.size() == 2) begin
            check("b_odd0", obs_b[0].o, exp_b0);
            check("b_odd1", obs_b[1].o, lift_ref(0, 30000, 30000, 1024));
            check("b_last1", obs_b[1].last, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
